// File: rtl/cpu_pkg.sv
// Shared VLIW bundle layout: widths, slot offsets, instruction field slices and
// the fetch-stage FSM encoding.
package cpu_pkg;

    localparam int BUNDLE_W = 88;
    localparam int SLOT_W   = 22;

    // Slot positions inside a bundle: [87:66]=A0 [65:44]=A1 [43:22]=M [21:0]=LS
    localparam int A0_LSB = 66;
    localparam int A1_LSB = 44;
    localparam int M_LSB  = 22;
    localparam int LS_LSB = 0;

    localparam logic [SLOT_W-1:0] NOP     = '0;
    localparam logic [4:0]        HALT_OP = 5'b11111;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    function automatic logic [4:0] slot_op(input logic [SLOT_W-1:0] s);
        return s[4:0];
    endfunction

    function automatic logic [4:0] slot_r0(input logic [SLOT_W-1:0] s);
        return s[9:5];
    endfunction

    function automatic logic [4:0] slot_r1(input logic [SLOT_W-1:0] s);
        return s[14:10];
    endfunction

    function automatic logic [4:0] slot_rd(input logic [SLOT_W-1:0] s);
        return s[19:15];
    endfunction

    function automatic logic [1:0] slot_cnd(input logic [SLOT_W-1:0] s);
        return s[21:20];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {bundle, pc_tag} entries; flush empties it
// in one cycle. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 104
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues bundle requests, tags responses with their PC,
// buffers them in a prefetch FIFO and presents the four slots to decode.
module instr_fetch #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [4:0]        HALT_OP    = cpu_pkg::HALT_OP
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic                        imem_gnt,
    input  logic                        imem_valid,
    input  logic [cpu_pkg::BUNDLE_W-1:0] imem_data,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [cpu_pkg::SLOT_W-1:0]  A0,
    output logic [cpu_pkg::SLOT_W-1:0]  A1,
    output logic [cpu_pkg::SLOT_W-1:0]  M,
    output logic [cpu_pkg::SLOT_W-1:0]  LS,
    output logic [ADDR_W-1:0]           if_pc,
    output logic                        if_valid,
    output logic                        halted
);

    import cpu_pkg::*;

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = BUNDLE_W + ADDR_W;

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  outstanding, outstanding_next, drop, fifo_count;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tag_wr, tag_rd;
    logic              issue, rsp, push, pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [BUNDLE_W-1:0] head_bundle;

    // Buffered plus in-flight bundles never exceed the FIFO, so a push always fits.
    assign occupancy        = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue            = imem_req & imem_gnt;
    assign rsp              = imem_valid && (outstanding != '0);
    assign outstanding_next = outstanding + CNT_W'(issue) - CNT_W'(rsp);
    assign push             = rsp && (drop == '0) && !redirect;
    assign pop              = if_valid && !stall && !redirect;
    assign imem_addr        = pc;

    always_comb begin
        state_next = state;
        imem_req   = (state == FS_RUN) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        halted     = (state == FS_HALT);
        unique case (state)
            FS_IDLE: state_next = FS_RUN;
            FS_RUN:  if (pop && slot_op(head_bundle[A0_LSB +: SLOT_W]) == HALT_OP)
                         state_next = FS_HALT;
            FS_HALT: state_next = FS_HALT;
            default: state_next = FS_IDLE;
        endcase
        if (redirect) state_next = FS_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (issue) tag_wr <= tag_wr + PTR_W'(1);
            if (rsp)   tag_rd <= tag_rd + PTR_W'(1);
            // Everything still in flight after this cycle belongs to the old stream.
            if (redirect) begin
                pc   <= redirect_pc;
                drop <= outstanding_next;
            end else begin
                if (issue) pc <= pc + ADDR_W'(1);
                if (rsp && drop != '0) drop <= drop - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) tag_mem[tag_wr] <= pc;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({imem_data, tag_mem[tag_rd]}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_bundle = head[ENTRY_W-1 -: BUNDLE_W];
    assign if_valid    = !fifo_empty;
    assign if_pc       = if_valid ? head[ADDR_W-1:0] : RESET_PC;
    assign A0          = if_valid ? head_bundle[A0_LSB +: SLOT_W] : NOP;
    assign A1          = if_valid ? head_bundle[A1_LSB +: SLOT_W] : NOP;
    assign M           = if_valid ? head_bundle[M_LSB  +: SLOT_W] : NOP;
    assign LS          = if_valid ? head_bundle[LS_LSB +: SLOT_W] : NOP;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_valid && outstanding == '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: an in-order memory model with adjustable
// grant/latency, a sequencer for the scenarios, and a scoreboard monitor.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_valid;
    logic [87:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [21:0] A0, A1, M, LS;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_cons = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mq_addr[$];
    int          mq_due[$];
    bit          rand_gnt = 0;
    bit          rand_lat = 0;
    int          fix_lat  = 1;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .A0          (A0),
        .A1          (A1),
        .M           (M),
        .LS          (LS),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: every field is a recognisable function of the address;
    // only address 0x0007 carries the halt opcode in A0.
    function automatic logic [87:0] bundle(input logic [15:0] a);
        logic [4:0] op;
        op = (a == 16'h0007) ? 5'b11111 : {1'b0, a[3:0]};
        return {1'b0, a, op, 6'h15, a, 6'h2A, ~a, 6'h33, a ^ 16'hA5A5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_seg(input logic [15:0] base);
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(base + 16'(k));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_slots", {A0 | A1 | M | LS}, 0);
        chk("rst_pc", if_pc, 16'h0000);
        chk("rst_halted", halted, 0);
    endtask

    // ---------------- memory driver ----------------
    initial begin
        imem_gnt   = 1'b0;
        imem_valid = 1'b0;
        imem_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq_addr.delete();
                mq_due.delete();
                imem_valid = 1'b0;
                imem_data  = '0;
                imem_gnt   = 1'b1;
                continue;
            end
            imem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
            if (imem_req && imem_gnt) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 4)) : fix_lat));
            end
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_valid = 1'b1;
                imem_data  = bundle(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                imem_valid = 1'b0;
                imem_data  = '0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        prev_redirect;
        logic        prev_stall_v;
        logic [15:0] held_pc;
        logic [87:0] b;
        prev_redirect = 0;
        prev_stall_v  = 0;
        held_pc       = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_redirect = 0;
                prev_stall_v  = 0;
                continue;
            end
            if (prev_redirect) chk("post_redirect_valid", if_valid, 0);
            if (!redirect) begin
                if (prev_stall_v) chk("stall_hold_pc", if_pc, held_pc);
                if (if_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("exp_underflow_pc", if_pc, 32'hFFFF_FFFF);
                    end else begin
                        b = bundle(exp_q[0]);
                        chk("head_pc", if_pc, exp_q[0]);
                        chk("slot_a0", A0, b[87:66]);
                        chk("slot_a1", A1, b[65:44]);
                        chk("slot_m", M, b[43:22]);
                        chk("slot_ls", LS, b[21:0]);
                        if (!stall) begin
                            void'(exp_q.pop_front());
                            n_cons++;
                        end
                    end
                end else begin
                    chk("empty_nop", {A0 | A1 | M | LS}, 0);
                end
            end
            prev_redirect = redirect;
            prev_stall_v  = if_valid && stall && !redirect;
            held_pc       = if_pc;
        end
    end

    // ---------------- sequencer ----------------
    initial begin
        int rq_n, first_req, first_val, start;
        bit seen, wrapped;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        load_seg(16'h0000);
        repeat (3) tick();
        chk_reset_outputs();
        rst = 1'b0;
        repeat (6) tick();

        // Reset in the middle of streaming
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) tick();
        load_seg(16'h0000);
        rst = 1'b0;

        // Streaming from reset with 1-cycle memory
        rq_n = 0; first_req = -1; first_val = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (imem_req && rq_n < 3) begin
                chk("issue_addr", imem_addr, 16'(rq_n));
                rq_n++;
            end
            if (imem_req && first_req < 0) first_req = cyc;
            if (if_valid && first_val < 0) first_val = cyc;
            if (if_valid && if_pc == 16'h0003) break;
        end
        chk("first_valid_latency", 32'(first_val - first_req), 2);
        chk("stall_target_pc", if_pc, 16'h0003);

        // Decode stall: head holds, fetch stops when buffer is full
        stall = 1'b1;
        repeat (6) tick();
        chk("stall_req_drop", imem_req, 0);
        chk("stall_head_pc", if_pc, 16'h0003);
        stall = 1'b0;
        for (int p = 4; p <= 6; p++) begin
            tick();
            chk("no_bubble_valid", if_valid, 1);
            chk("no_bubble_pc", if_pc, 16'(p));
        end

        // Halt on bundle 7
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted) break;
        end
        chk("halt_set", halted, 1);
        chk("halt_req", imem_req, 0);
        repeat (4) tick();
        chk("halt_hold", halted, 1);
        chk("halt_hold_req", imem_req, 0);

        // Redirect out of halt
        redirect = 1'b1; redirect_pc = 16'h0010; load_seg(16'h0010);
        tick();
        redirect = 1'b0;
        chk("resume_halted", halted, 0);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 16'h0010);

        // Redirect with responses in flight
        repeat (4) tick();
        fix_lat = 3;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mq_addr.size() >= 2) break;
        end
        chk("inflight_before_redirect", 32'(mq_addr.size() >= 2), 1);
        redirect = 1'b1; redirect_pc = 16'h0040; load_seg(16'h0040);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) break;
            tick();
        end
        chk("redirect_first_pc", if_pc, 16'h0040);
        fix_lat = 1;
        repeat (4) tick();

        // PC wrap
        redirect = 1'b1; redirect_pc = 16'hFFFF; load_seg(16'hFFFF);
        tick();
        redirect = 1'b0;
        seen = 0; wrapped = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) begin
                if (seen) begin
                    chk("wrap_addr", imem_addr, 16'h0000);
                    wrapped = 1;
                    break;
                end
                if (imem_addr == 16'hFFFF) seen = 1;
            end
            tick();
        end
        chk("wrap_reached", wrapped, 1);
        repeat (6) tick();

        // Random grant, latency and stall
        redirect = 1'b1; redirect_pc = 16'h0100; load_seg(16'h0100);
        rand_gnt = 1; rand_lat = 1;
        tick();
        redirect = 1'b0;
        start = n_cons;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall = ($urandom_range(0, 3) == 0);
            if (n_cons - start >= 40) break;
        end
        chk("random_progress", 32'(n_cons - start >= 40), 1);
        stall = 1'b0; rand_gnt = 0; rand_lat = 0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
